vdp_port: RTL

VDP_PORT -- requirements
Module: vdp_port

---
 rtl/vdp_port.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vdp_port.sv
// vdp_port: CPU-facing register/VRAM port of a TMS9918-style video chip.
// Two I/O ports (data, control/status), eight write-only registers, a 14-bit
// auto-incrementing VRAM address and a two-cycle read-ahead prefetch.
module vdp_port (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_sel,
  input  logic        cpu_port,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_din,
  output logic        vram_wr,
  input  logic [7:0]  vram_dout,
  input  logic        frame,
  output logic        n_int,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] font_addr,
  output logic        video_on,
  output logic [7:0]  backdrop
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} pf_state_t;

  pf_state_t       state, state_nxt;
  logic [7:0][7:0] regs;
  logic [13:0]     addr;
  logic [13:0]     wr_addr;
  logic [7:0]      wr_data;
  logic [7:0]      low_byte;
  logic            flag;
  logic [7:0]      buffer;
  logic            f_flag;
  logic            acc_rd, acc_wr, pf_start;

  // Accepted strobes: selected, not stalled, and exactly one of rd/wr.
  always_comb begin
    acc_rd   = cpu_sel & ~cpu_wait & cpu_rd & ~cpu_wr;
    acc_wr   = cpu_sel & ~cpu_wait & cpu_wr & ~cpu_rd;
    pf_start = (acc_rd & ~cpu_port) |
               (acc_wr & cpu_port & flag & ~cpu_din[7] & ~cpu_din[6]);
  end

  // Prefetch FSM state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Prefetch FSM next state; the CPU is stalled whenever not idle.
  always_comb begin
    state_nxt = state;
    cpu_wait  = (state != IDLE);
    case (state)
      IDLE:    if (pf_start) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register file, address pointer, read buffer, status flag and write pulse.
  // Strobes are only accepted in IDLE, so they never collide with CAPTURE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      regs     <= '0;
      addr     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      low_byte <= '0;
      flag     <= 1'b0;
      buffer   <= '0;
      f_flag   <= 1'b0;
      cpu_dout <= '0;
      vram_wr  <= 1'b0;
    end else begin
      vram_wr <= 1'b0;
      if (state == CAPTURE) begin
        buffer <= vram_dout;
        addr   <= addr + 14'd1;
      end
      if (acc_wr && !cpu_port) begin
        vram_wr <= 1'b1;
        wr_addr <= addr;
        wr_data <= cpu_din;
        buffer  <= cpu_din;
        addr    <= addr + 14'd1;
        flag    <= 1'b0;
      end
      if (acc_wr && cpu_port) begin
        if (!flag) begin
          low_byte <= cpu_din;
          flag     <= 1'b1;
        end else begin
          flag <= 1'b0;
          if (cpu_din[7]) regs[cpu_din[2:0]] <= low_byte;
          else            addr <= {cpu_din[5:0], low_byte};
        end
      end
      if (acc_rd && !cpu_port) begin
        cpu_dout <= buffer;
        flag     <= 1'b0;
      end
      if (acc_rd && cpu_port) begin
        cpu_dout <= {f_flag, 7'b0};
        f_flag   <= 1'b0;
        flag     <= 1'b0;
      end
      // Placed last so a vblank in the same cycle as a status read wins.
      if (frame) f_flag <= 1'b1;
    end
  end

  // VRAM port: the write pulse carries its own latched address, since addr
  // has already advanced by the time vram_wr is high.
  always_comb begin
    vram_addr = vram_wr ? wr_addr : addr;
    vram_din  = wr_data;
  end

  // Decoded register views.
  always_comb begin
    n_int           = ~(f_flag & regs[1][5]);
    video_on        = regs[1][6];
    if (regs[1][4])      mode = 2'd0;
    else if (regs[0][1]) mode = 2'd2;
    else if (regs[1][3]) mode = 2'd3;
    else                 mode = 2'd1;
    name_table_addr = {regs[2][3:0], 10'b0};
    font_addr       = {regs[4][2:0], 11'b0};
    backdrop        = regs[7];
  end

endmodule
